divider: RTL and testbench
==========================

# divider

Sequential signed/unsigned divider: the inverse of the team's 26×14 multiplier. Takes a 40-bit (M+N) dividend and a 14-bit (N) divisor, produces a 26-bit (M) quotient and a 14-bit (N) remainder, one quotient bit per clock using a restoring algorithm. Sits beside `multiplier` in the datapath, so a multiplier product fed back with the same multiplier operand recovers the original multiplicand.

## Interface
- `M`, 26, quotient width.
- `N`, 14, divisor and remainder width; the dividend is M+N bits wide.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; accepted only while `busy`=0.
- `dividend`  in  M+N  sampled on the accepting edge.
- `divisor`  in  N  sampled on the accepting edge.
- `busy`  out  1  high in CALC and FIX.
- `done`  out  1  single-cycle pulse; results are valid in that cycle.
- `quotient`  out  M  result; held until the next accepted start.
- `remainder`  out  N  result; held until the next accepted start.
- `div_by_zero`  out  1  error flag, valid with `done`.
- `overflow`  out  1  error flag, valid with `done`.

## Operation
- States and transitions:
  - IDLE: wait for `start`.
  - CALC: M cycles, bit counter M-1 down to 0.
  - FIX: 1 cycle.
  - DONE: 1 cycle.
- Start is accepted in IDLE or DONE when `start`=1.
- On accept:
  - Latch the operand magnitudes and signs; clear both flags.
  - If divisor==0: set `div_by_zero` and go to DONE.
  - Else if dividend_mag[M+N-1:M] >= divisor_mag: set `overflow` and go to DONE. The quotient cannot fit in M bits.
  - Else go to CALC.
- CALC step: shift the partial remainder left by one and bring in the next dividend bit. Trial-subtract the divisor magnitude. If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0. The partial remainder is N+1 bits wide.
- FIX:
  - Apply signs: quotient is negative if the operand signs differ; remainder takes the dividend's sign (truncating division).
  - Signed overflow: set `overflow` if the quotient magnitude exceeds 2^(M-1)-1. Magnitude exactly 2^(M-1) is legal when the result is negative.
- Error results: `quotient`=0 and `remainder`=0 whenever either flag is set.
- DONE: assert `done`, return to IDLE. An accepted `start` in DONE goes directly to CALC or DONE, so back-to-back operations are allowed.
- `start` while `busy`=1 is ignored. It is not queued.
- Reset applies in any state, including mid-CALC: go to IDLE and drive every output to 0 (`busy`, `done`, `quotient`, `remainder`, `div_by_zero`, `overflow`). No `done` is issued for the aborted operation.

## Timing
- Accepting edge = cycle 0.
- Normal path:
  - CALC in cycles 1..M, FIX in cycle M+1.
  - `done` high in cycle M+2 (cycle 28 at the defaults).
- Error path: `done` high in cycle 1.
- `busy` rises in cycle 1 on the normal path and falls in the DONE cycle. It never rises on the error path.
- Outputs update only in the FIX cycle or the error-accept cycle.

## Configuration
- `DIVIDER_SIGNED_EN` defined: operands are two's complement. Magnitude conversion, sign fix-up and the signed overflow check are all present.
- Undefined: operands are unsigned. FIX does no sign handling; `overflow` comes only from the accept-time check. FIX is kept as an empty cycle so latency is identical in both builds.

## Structure
- `divider_pkg`:
  - width constants `DIV_M`=26, `DIV_N`=14;
  - state enum (IDLE, CALC, FIX, DONE);
  - counter width `$clog2(DIV_M)`.
- One sub-module, `divider_step`: combinational shift, trial-subtract and select for one CALC iteration. The top level holds the FSM, registers and sign logic.

## Test plan
- Signed inverse of the multiplier: dividend = −11888676 (0x050A01 × −36), divisor = −36 (14'h3FDC) -> quotient 0x050A01, remainder 0, flags 0, `done` at cycle 28.
- Truncation signs: dividend −7, divisor 2 -> quotient −3, remainder −1. Dividend 7, divisor −2 -> quotient −3, remainder 1.
- Divide by zero: divisor 0 -> `div_by_zero`=1, `quotient`=0, `remainder`=0, `done` at cycle 1, `busy` never high.
- Overflow:
  - dividend 2^38, divisor 1 -> `overflow`=1 at cycle 1 (accept-time check);
  - signed build, dividend 2^25, divisor 1 -> `overflow`=1 at cycle 28 (FIX check);
  - dividend −2^25, divisor 1 -> quotient −2^25, no flag.
- Handshake:
  - `start` pulsed during CALC -> ignored; the first result is unchanged;
  - `start` held high in the DONE cycle -> a new operation is accepted, with its `done` 28 cycles later.
- Reset mid-operation: `rst` asserted at cycle 10 -> next cycle all outputs 0 and state IDLE; no `done` follows. A new start then completes normally.

Source files
------------

// File: rtl/divider_pkg.sv
// divider_pkg: shared constants and types for the sequential divider.
//   DIV_M   quotient width (26)
//   DIV_N   divisor / remainder width (14); the dividend is DIV_M+DIV_N bits
//   DIV_CW  width of the CALC bit counter
//   state_t controller states
package divider_pkg;

  localparam int DIV_M  = 26;
  localparam int DIV_N  = 14;
  localparam int DIV_CW = $clog2(DIV_M);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // A new request can only be taken while the datapath is not in use.
  function automatic logic can_accept(input state_t s);
    return (s == IDLE) || (s == DONE);
  endfunction

endpackage

// File: rtl/divider_step.sv
// divider_step: one restoring-division iteration (purely combinational).
// Ports:
//   rem_in       partial remainder from the previous step (always < divisor_mag)
//   bit_in       next dividend bit, MSB first
//   divisor_mag  divisor magnitude
//   rem_out      partial remainder after trial-subtract / restore
//   q_bit        quotient bit produced by this step
module divider_step
  import divider_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic [N-1:0] rem_in,
  input  logic         bit_in,
  input  logic [N-1:0] divisor_mag,
  output logic [N-1:0] rem_out,
  output logic         q_bit
);

  logic [N:0] shifted;

  // The shifted value needs N+1 bits, but whatever survives the
  // subtract/restore is below the divisor, so it fits back into N bits.
  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= {1'b0, divisor_mag});
    rem_out = q_bit ? N'(shifted - {1'b0, divisor_mag}) : N'(shifted);
  end

endmodule

// File: rtl/divider.sv
// divider: sequential restoring divider, one quotient bit per clock.
// Build option: define DIVIDER_SIGNED_EN for two's-complement operands
// (magnitude conversion, sign fix-up and signed range check); otherwise the
// operands are unsigned and FIX is an empty cycle of equal latency.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                request; taken only when not busy (IDLE or DONE)
//   dividend, divisor    operands, sampled on the accepting edge
//   busy                 high in CALC and FIX
//   done                 one-cycle pulse, results valid in that cycle
//   quotient, remainder  results, held until the next accepted start
//   div_by_zero          divisor was zero
//   overflow             quotient does not fit in M bits
module divider
  import divider_pkg::*;
#(
  parameter int M = DIV_M,
  parameter int N = DIV_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [M+N-1:0]   dividend,
  input  logic [N-1:0]     divisor,
  output logic             busy,
  output logic             done,
  output logic [M-1:0]     quotient,
  output logic [N-1:0]     remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int W  = M + N;
  localparam int CW = $clog2(M);

  state_t         state, state_next;
  logic           accept;
  logic [W-1:0]   dividend_mag;
  logic [N-1:0]   divisor_mag;
  logic           err_zero, err_range;

  logic [N-1:0]   divisor_reg;
  logic [N-1:0]   rem_reg;
  logic [M-1:0]   shift_reg;
  logic [CW-1:0]  count;

  logic [N-1:0]   step_rem;
  logic           step_bit;

`ifdef DIVIDER_SIGNED_EN
  localparam logic [M-1:0] Q_MIN_MAG = {1'b1, {(M-1){1'b0}}};
  logic sign_dividend, sign_quotient;
  logic q_over;

  // Negating the most negative value yields the same bit pattern, which read
  // as unsigned is exactly its magnitude.
  assign dividend_mag = dividend[W-1] ? -dividend : dividend;
  assign divisor_mag  = divisor[N-1]  ? -divisor  : divisor;
  // A negative result may reach -2^(M-1); a positive one must stay below 2^(M-1).
  assign q_over = sign_quotient ? (shift_reg > Q_MIN_MAG) : shift_reg[M-1];
`else
  assign dividend_mag = dividend;
  assign divisor_mag  = divisor;
`endif

  assign accept    = start && can_accept(state);
  assign err_zero  = (divisor_mag == '0);
  // Upper half >= divisor means the quotient needs more than M bits.
  assign err_range = (dividend_mag[W-1:M] >= divisor_mag);

  divider_step #(.N(N)) u_step (
    .rem_in      (rem_reg),
    .bit_in      (shift_reg[M-1]),
    .divisor_mag (divisor_reg),
    .rem_out     (step_rem),
    .q_bit       (step_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE, DONE: begin
        done       = (state == DONE);
        state_next = IDLE;
        if (accept) state_next = (err_zero || err_range) ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (count == '0) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // shift_reg starts as the low dividend bits and is consumed MSB-first while
  // quotient bits enter at the LSB, so it ends up holding the quotient magnitude.
  always_ff @(posedge clk) begin
    if (rst) begin
      quotient      <= '0;
      remainder     <= '0;
      div_by_zero   <= 1'b0;
      overflow      <= 1'b0;
      divisor_reg   <= '0;
      rem_reg       <= '0;
      shift_reg     <= '0;
      count         <= '0;
`ifdef DIVIDER_SIGNED_EN
      sign_dividend <= 1'b0;
      sign_quotient <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            div_by_zero <= err_zero;
            overflow    <= err_range && !err_zero;
            divisor_reg <= divisor_mag;
            rem_reg     <= dividend_mag[W-1:M];
            shift_reg   <= dividend_mag[M-1:0];
            count       <= CW'(M - 1);
`ifdef DIVIDER_SIGNED_EN
            sign_dividend <= dividend[W-1];
            sign_quotient <= dividend[W-1] ^ divisor[N-1];
`endif
            if (err_zero || err_range) begin
              quotient  <= '0;
              remainder <= '0;
            end
          end
        end
        CALC: begin
          rem_reg   <= step_rem;
          shift_reg <= {shift_reg[M-2:0], step_bit};
          count     <= count - CW'(1);
        end
        FIX: begin
`ifdef DIVIDER_SIGNED_EN
          if (q_over) begin
            overflow  <= 1'b1;
            quotient  <= '0;
            remainder <= '0;
          end else begin
            quotient  <= sign_quotient ? -shift_reg : shift_reg;
            remainder <= sign_dividend ? -rem_reg   : rem_reg;
          end
`else
          quotient  <= shift_reg;
          remainder <= rem_reg;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// tb_divider: self-checking bench for divider. A reference model computes
// results with plain integer division and tracks when done/busy must appear;
// a compare process checks every output on every cycle after reset.
// Honours DIVIDER_SIGNED_EN the same way as the design.
module tb_divider;

  localparam int M = 26;
  localparam int N = 14;
  localparam int W = M + N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy, done;
  logic [M-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero, overflow;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Reference: plain integer division. Latency 1 for errors caught at
  // accept time, 28 otherwise.
  function automatic void refModel(input logic [W-1:0] a, input logic [N-1:0] b,
                                   output logic [M-1:0] q, output logic [N-1:0] r,
                                   output bit dz, output bit ov, output int lat);
    longint sa, sb, am, bm, qa, ra;
    logic signed [W-1:0] as_v;
    logic signed [N-1:0] bs_v;
    q = '0; r = '0; dz = 0; ov = 0; lat = M + 2;
`ifdef DIVIDER_SIGNED_EN
    as_v = a; bs_v = b;
    sa = as_v; sb = bs_v;
`else
    sa = longint'(a); sb = longint'(b);
`endif
    if (sb == 0) begin dz = 1; lat = 1; return; end
    am = (sa < 0) ? -sa : sa;
    bm = (sb < 0) ? -sb : sb;
    if (am / bm >= (64'sd1 << M)) begin ov = 1; lat = 1; return; end
    qa = sa / sb;
    ra = sa % sb;
`ifdef DIVIDER_SIGNED_EN
    if (qa > (64'sd1 << (M-1)) - 1 || qa < -(64'sd1 << (M-1))) begin ov = 1; return; end
`endif
    q = qa[M-1:0];
    r = ra[N-1:0];
  endfunction

  // Model timeline: edge_cnt numbers rising edges; done_edge is the edge
  // after which done must be high.
  bit           model_on = 0;
  bit           pend = 0, pend_normal = 0;
  int           edge_cnt = 0, acc_edge = 0, done_edge = 0;
  logic [M-1:0] res_q, vis_q;
  logic [N-1:0] res_r, vis_r;
  bit           res_dz, res_ov, vis_dz, vis_ov;

  always @(posedge clk) begin : model_proc
    logic [M-1:0] mq;
    logic [N-1:0] mr;
    bit           mdz, mov;
    int           mlat;
    edge_cnt++;
    if (rst) begin
      model_on = 1; pend = 0;
      vis_q = '0; vis_r = '0; vis_dz = 0; vis_ov = 0;
    end else if (model_on) begin
      if (start && !(pend && edge_cnt - 1 < done_edge)) begin
        refModel(dividend, divisor, mq, mr, mdz, mov, mlat);
        pend = 1; pend_normal = (mlat != 1);
        acc_edge = edge_cnt; done_edge = edge_cnt + mlat - 1;
        res_q = mq; res_r = mr; res_dz = mdz; res_ov = mov;
        vis_dz = 0; vis_ov = 0;
      end
      if (pend && edge_cnt == done_edge) begin
        vis_q = res_q; vis_r = res_r; vis_dz = res_dz; vis_ov = res_ov;
      end
    end
  end

  always @(negedge clk) begin : compare_proc
    bit eb, ed;
    if (model_on) begin
      eb = pend && pend_normal && edge_cnt >= acc_edge && edge_cnt < done_edge;
      ed = pend && edge_cnt == done_edge;
      checkOutput("busy", busy, eb);
      checkOutput("done", done, ed);
      checkOutput("quotient", quotient, vis_q);
      checkOutput("remainder", remainder, vis_r);
      checkOutput("div_by_zero", div_by_zero, vis_dz);
      checkOutput("overflow", overflow, vis_ov);
    end
  end

  // Called on a falling edge; returns one falling edge later (cycle 1).
  task automatic applyStimulus(input logic [W-1:0] a, input logic [N-1:0] b);
    dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int lat0, output int lat);
    lat = lat0;
    while (done !== 1'b1 && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) begin
      checks++; failures++;
      $display("[TB] FAIL done_timeout: got no done, expected done within 80 cycles at t=%0t", $time);
    end
  endtask

  task automatic runDirected(input string name, input logic [W-1:0] a, input logic [N-1:0] b,
                             input logic [M-1:0] eq, input logic [N-1:0] er,
                             input logic edz, input logic eov, input int elat);
    int lat;
    applyStimulus(a, b);
    waitDone(1, lat);
    checkOutput({name, "_latency"}, lat, elat);
    checkOutput({name, "_q"}, quotient, eq);
    checkOutput({name, "_r"}, remainder, er);
    checkOutput({name, "_dz"}, div_by_zero, edz);
    checkOutput({name, "_ov"}, overflow, eov);
    @(negedge clk);
  endtask

  task automatic noDoneFor(input string name, input int cycles);
    bit seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    checkOutput(name, seen, 0);
  endtask

  task automatic randomOperands(output logic [W-1:0] a, output logic [N-1:0] b);
    logic [63:0]         rnd;
    logic signed [W-1:0] sa;
    rnd = {$urandom, $urandom};
    sa  = rnd[W-1:0];
    case ($urandom_range(0, 3))
      0:       a = rnd[W-1:0];
      1:       a = sa >>> $urandom_range(10, 39);
      2:       a = rnd[W-1:0] >> $urandom_range(14, 39);
      default: a = sa >>> N;
    endcase
    case ($urandom_range(0, 9))
      0:       b = '0;
      1:       b = 14'd1;
      2:       b = 14'h2000;
      3:       b = 14'h3FFF;
      default: b = 14'($urandom);
    endcase
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected end before 2000000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    logic [W-1:0] ra;
    logic [N-1:0] rb;
    int           lat;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_q", quotient, 0);
    checkOutput("reset_r", remainder, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed cases");
`ifdef DIVIDER_SIGNED_EN
    runDirected("inverse",   40'hFFFF4A97DC, 14'h3FDC, 26'h050A01, 14'h0000, 0, 0, 28);
    runDirected("trunc_a",   40'hFFFFFFFFF9, 14'd2,    26'h3FFFFFD, 14'h3FFF, 0, 0, 28);
    runDirected("trunc_b",   40'd7,          14'h3FFE, 26'h3FFFFFD, 14'd1,    0, 0, 28);
    runDirected("fix_ovf",   40'h0002000000, 14'd1,    26'h0,       14'h0,    0, 1, 28);
    runDirected("min_quot",  40'hFFFE000000, 14'd1,    26'h2000000, 14'h0,    0, 0, 28);
`else
    runDirected("inverse",   40'hFFFF4A97DC, 14'h3FDC, 26'h0,       14'h0,    0, 1, 1);
    runDirected("trunc_a",   40'hFFFFFFFFF9, 14'd2,    26'h0,       14'h0,    0, 1, 1);
    runDirected("trunc_b",   40'd7,          14'h3FFE, 26'h0,       14'd7,    0, 0, 28);
    runDirected("fix_ovf",   40'h0002000000, 14'd1,    26'h2000000, 14'h0,    0, 0, 28);
    runDirected("min_quot",  40'hFFFE000000, 14'd1,    26'h0,       14'h0,    0, 1, 1);
`endif
    runDirected("div_zero",  40'd1234,         14'd0, 26'h0,     14'h0,  1, 0, 1);
    runDirected("acc_ovf",   40'h4000000000,   14'd1, 26'h0,     14'h0,  0, 1, 1);
    runDirected("plain",     40'd100000,       14'd7, 26'd14285, 14'd5,  0, 0, 28);

    $display("[TB] start ignored while busy");
    applyStimulus(40'd100000, 14'd7);
    repeat (4) @(negedge clk);
    applyStimulus(40'd1, 14'd1);
    waitDone(6, lat);
    checkOutput("ignore_latency", lat, 28);
    checkOutput("ignore_q", quotient, 14285);
    checkOutput("ignore_r", remainder, 5);
    noDoneFor("ignore_no_extra_done", 35);

    $display("[TB] back-to-back start in DONE cycle");
    applyStimulus(40'd100000, 14'd7);
    waitDone(1, lat);
    checkOutput("b2b_first_q", quotient, 14285);
    applyStimulus(40'd1000, 14'd3);
    waitDone(1, lat);
    checkOutput("b2b_latency", lat, 28);
    checkOutput("b2b_q", quotient, 333);
    checkOutput("b2b_r", remainder, 1);
    @(negedge clk);

    $display("[TB] reset mid-operation");
    applyStimulus(40'd100000, 14'd7);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_q", quotient, 0);
    checkOutput("midrst_r", remainder, 0);
    checkOutput("midrst_dz", div_by_zero, 0);
    checkOutput("midrst_ov", overflow, 0);
    noDoneFor("midrst_no_done", 40);
    runDirected("after_rst", 40'd1000, 14'd3, 26'd333, 14'd1, 0, 0, 28);

    $display("[TB] randomized operations");
    for (int i = 0; i < 150; i++) begin
      randomOperands(ra, rb);
      dividend = ra; divisor = rb; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 80) begin
        if ($urandom_range(0, 7) == 0) begin
          dividend = {$urandom, $urandom};
          divisor  = 14'($urandom);
          start    = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        lat++;
      end
      if (done !== 1'b1) begin
        checks++; failures++;
        $display("[TB] FAIL random_timeout: got no done, expected done for op %0d", i);
      end
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
